// File: rtl/hamming_encoder_tx.sv
// Hamming(7,4) encoder with overall even parity bit, feeding a small codeword FIFO.
// Optional per-push error injection lets the downstream decoder be exercised.
module hamming_encoder_tx #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       inj_en,
    input  logic [7:0] inj_mask,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic [3:0] level
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    level_q, level_d;
    logic          push, pop;
    logic [7:0]    codeword;

    assign in_ready  = (level_q != 4'(DEPTH));
    assign out_valid = (level_q != 4'd0);
    assign level     = level_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Bit map: [0]=P1 [1]=P2 [2]=D1 [3]=P3 [4]=D2 [5]=D3 [6]=D4 [7]=overall parity
    always_comb begin
        codeword    = 8'h00;
        codeword[2] = in_data[0];
        codeword[4] = in_data[1];
        codeword[5] = in_data[2];
        codeword[6] = in_data[3];
        codeword[0] = in_data[0] ^ in_data[1] ^ in_data[3];
        codeword[1] = in_data[0] ^ in_data[2] ^ in_data[3];
        codeword[3] = in_data[1] ^ in_data[2] ^ in_data[3];
        codeword[7] = ^codeword[6:0];
        if (inj_en) begin
            codeword = codeword ^ inj_mask;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: contents are only visible while level is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= codeword;
        end
    end

    assign out_data = out_valid ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Self-checking bench for hamming_encoder_tx: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_hamming_encoder_tx;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_ready;
    logic       inj_en = 1'b0;
    logic [7:0] inj_mask = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [3:0] level;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] mq[$];

    hamming_encoder_tx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .inj_en    (inj_en),
        .inj_mask  (inj_mask),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Classic Hamming rule: parity at position 2^k covers every position with bit k set.
    function automatic logic [7:0] ref_encode(input logic [3:0] d);
        logic [7:0] cw;
        int data_pos[4] = '{3, 5, 6, 7};
        logic p;
        cw = 8'h00;
        for (int i = 0; i < 4; i++) cw[data_pos[i] - 1] = d[i];
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos & (1 << k)) != 0) && (pos != (1 << k))) p = p ^ cw[pos - 1];
            cw[(1 << k) - 1] = p;
        end
        cw[7] = ^cw[6:0];
        return cw;
    endfunction

    task automatic drive(input logic v, input logic [3:0] d, input logic ie,
                         input logic [7:0] m, input logic ordy);
        in_valid  = v;
        in_data   = d;
        inj_en    = ie;
        inj_mask  = m;
        out_ready = ordy;
    endtask

    // Advance one clock edge, updating the model from the pre-edge inputs.
    task automatic tick();
        bit do_pop, do_push;
        logic [7:0] cw;
        do_pop  = rstn && out_ready && (mq.size() != 0);
        do_push = rstn && in_valid && (mq.size() != DEPTH);
        cw = ref_encode(in_data) ^ (inj_en ? inj_mask : 8'h00);
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(cw);
        #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got %h want 00", out_data); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk); #3;
        rstn = 1'b1;
        mq.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        drive(1'b1, 4'hB, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
        vectors++; if (out_data !== 8'h55) begin miscompares++; $display("FAIL single_data got %h want 55", out_data); end
        vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL single_level got %0d want 1", level); end
        tick();
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL single_drain got %0d want 0", level); end
    endtask

    task automatic test_sequence();
        drive(1'b1, 4'h0, 1'b0, 8'h00, 1'b1);
        tick();
        vectors++; if (out_data !== 8'h00 || out_valid !== 1'b1) begin miscompares++; $display("FAIL seq_zero got %h/%b want 00/1", out_data, out_valid); end
        drive(1'b1, 4'hF, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        vectors++; if (out_data !== 8'hFF) begin miscompares++; $display("FAIL seq_ones got %h want FF", out_data); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL seq_empty got %b want 0", out_valid); end
    endtask

    task automatic test_fill();
        logic [7:0] exp_cw[$];
        logic [3:0] d;
        for (int i = 0; i <= DEPTH; i++) begin
            d = 4'($urandom_range(15));
            drive(1'b1, d, 1'b0, 8'h00, 1'b0);
            if (i < DEPTH) exp_cw.push_back(ref_encode(d));
            vectors++; if (in_ready !== (i < DEPTH)) begin miscompares++; $display("FAIL fill_ready[%0d] got %b want %b", i, in_ready, i < DEPTH); end
            tick();
        end
        vectors++; if (level !== 4'(DEPTH)) begin miscompares++; $display("FAIL fill_level got %0d want %0d", level, DEPTH); end
        drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            vectors++; if (out_data !== exp_cw[i] || out_valid !== 1'b1) begin miscompares++; $display("FAIL fill_drain[%0d] got %h want %h", i, out_data, exp_cw[i]); end
            tick();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fill_extra_stored got %b want 0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 4'($urandom_range(15)), 1'b0, 8'h00, 1'b0);
            tick();
        end
        drive(1'b1, 4'h7, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b0);
        vectors++; if (level !== 4'(DEPTH - 1)) begin miscompares++; $display("FAIL fullpp_level got %0d want %0d", level, DEPTH - 1); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fullpp_ready got %b want 1", in_ready); end
        drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            vectors++; if (out_data !== mq[0]) begin miscompares++; $display("FAIL fullpp_drain[%0d] got %h want %h", i, out_data, mq[0]); end
            tick();
        end
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL fullpp_empty got %0d want 0", level); end
    endtask

    task automatic test_inject();
        drive(1'b1, 4'hB, 1'b1, 8'h04, 1'b1);
        tick();
        vectors++; if (out_data !== 8'h51) begin miscompares++; $display("FAIL inj_04 got %h want 51", out_data); end
        drive(1'b1, 4'hB, 1'b1, 8'h0C, 1'b1);
        tick();
        vectors++; if (out_data !== 8'h59) begin miscompares++; $display("FAIL inj_0C got %h want 59", out_data); end
        drive(1'b0, 4'h0, 1'b1, 8'hFF, 1'b1);
        tick();
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL inj_idle got %0d want 0", level); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'($urandom_range(15)), 1'b0, 8'h00, 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b0);
        vectors++; if (level !== 4'd3) begin miscompares++; $display("FAIL arst_pre got %0d want 3", level); end
        #2;
        rstn = 1'b0;
        mq.delete();
        #1;
        vectors++; if (out_valid !== 1'b0 || level !== 4'd0) begin miscompares++; $display("FAIL arst_now got %b/%0d want 0/0", out_valid, level); end
        vectors++; if (out_data !== 8'h00 || in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_outs got %h/%b want 00/1", out_data, in_ready); end
        tick();
        rstn = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_stale got %b want 0", out_valid); end
        drive(1'b1, 4'h6, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 8'h00, 1'b1);
        vectors++; if (out_valid !== 1'b1 || out_data !== ref_encode(4'h6)) begin miscompares++; $display("FAIL arst_first got %b/%h want 1/%h", out_valid, out_data, ref_encode(4'h6)); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_data;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(1)), 4'($urandom_range(15)), ($urandom_range(3) == 0),
                  8'($urandom_range(255)), ($urandom_range(2) != 0));
            exp_data = (mq.size() != 0) ? mq[0] : 8'h00;
            vectors++; if (out_data !== exp_data) begin miscompares++; $display("FAIL rand_data[%0d] got %h want %h", n, out_data, exp_data); end
            vectors++; if (level !== 4'(mq.size())) begin miscompares++; $display("FAIL rand_level[%0d] got %0d want %0d", n, level, mq.size()); end
            vectors++; if (in_ready !== (mq.size() != DEPTH)) begin miscompares++; $display("FAIL rand_ready[%0d] got %b want %b", n, in_ready, mq.size() != DEPTH); end
            vectors++; if (out_valid !== (mq.size() != 0)) begin miscompares++; $display("FAIL rand_valid[%0d] got %b want %b", n, out_valid, mq.size() != 0); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_fill();
        test_full_push_pop();
        test_inject();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hamming_encoder_tx.md
HAMMING_ENCODER_TX -- requirements
Module: hamming_encoder_tx

Interface
REQ-001 Parameter: DEPTH, default 4; number of codeword buffer entries; legal values 2, 4 or 8.
REQ-002 Port: clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-003 Port: rstn, input, 1 bit; asynchronous, active-low reset.
REQ-004 Port: in_valid, input, 1 bit; upstream presents a nibble.
REQ-005 Port: in_data, input, 4 bits; payload, D1=in_data[0], D2=[1], D3=[2], D4=[3].
REQ-006 Port: in_ready, output, 1 bit; block can accept a nibble.
REQ-007 Port: inj_en, input, 1 bit; apply error injection to the nibble accepted this cycle.
REQ-008 Port: inj_mask, input, 8 bits; bits XORed into the codeword when inj_en=1.
REQ-009 Port: out_valid, output, 1 bit; out_data holds a buffered codeword.
REQ-010 Port: out_data, output, 8 bits; codeword toward the decoder stage.
REQ-011 Port: out_ready, input, 1 bit; downstream accepts out_data.
REQ-012 Port: level, output, 4 bits; current buffer occupancy, 0..DEPTH.

Function
REQ-013 Codeword bit map SHALL be: [0]=P1, [1]=P2, [2]=D1, [3]=P3, [4]=D2, [5]=D3, [6]=D4, [7]=P4.
REQ-014 P1 SHALL equal D1^D2^D4; P2 SHALL equal D1^D3^D4; P3 SHALL equal D2^D3^D4.
REQ-015 P4 SHALL equal the XOR of codeword bits [6:0], giving even overall parity.
REQ-016 Accept (push) SHALL occur on a clock edge where in_valid=1 and in_ready=1.
REQ-017 On push, the block SHALL store the encoded codeword, XORed with inj_mask when inj_en=1, at the write pointer.
REQ-018 inj_en and inj_mask SHALL be ignored on cycles without a push.
REQ-019 Release (pop) SHALL occur on a clock edge where out_valid=1 and out_ready=1.
REQ-020 out_data SHALL show the entry at the read pointer whenever out_valid=1, and SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 out_data SHALL be 8'h00 when out_valid=0.
REQ-022 in_ready SHALL equal (level != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-023 out_valid SHALL equal (level != 0); there SHALL be no input-to-output bypass.
REQ-024 Minimum latency from push to out_valid SHALL be 1 cycle.
REQ-025 Push+pop on the same edge SHALL leave level unchanged and advance both pointers.
REQ-026 Push alone SHALL increment level; pop alone SHALL decrement level.
REQ-027 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 Codewords SHALL leave in acceptance order with no loss or duplication.
REQ-029 When full, in_valid SHALL be ignored even if a pop occurs on the same edge; the slot frees on the following cycle.

Reset
REQ-030 While rstn=0, level SHALL be 0, out_valid SHALL be 0, out_data SHALL be 8'h00, in_ready SHALL be 1, and both pointers SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered codewords immediately, without waiting for a clock edge.
REQ-032 The first push after rstn deasserts SHALL be accepted on the first rising edge where in_valid=1.

Verification
REQ-033 in_data=4'hB, inj_en=0, out_ready=1 -> out_valid=1 one cycle later, out_data=8'h55, level returns to 0.
REQ-034 in_data sequence 4'h0, 4'hF with out_ready=1 -> out_data 8'h00 then 8'hFF on consecutive cycles.
REQ-035 out_ready=0, DEPTH+1 back-to-back pushes -> in_ready=0 after DEPTH accepts; level=DEPTH; extra nibble not stored; draining returns codewords in order.
REQ-036 Full buffer, in_valid=1 and out_ready=1 on the same edge -> one pop only, level=DEPTH-1, in_ready=1 on the next cycle.
REQ-037 in_data=4'hB with inj_en=1, inj_mask=8'h04 -> out_data=8'h51; with inj_mask=8'h0C -> out_data=8'h59.
REQ-038 3 entries buffered, rstn pulsed low between clock edges -> out_valid=0 and level=0 immediately; no stale codeword after release.
